// File: rtl/rb_commit_unit_pkg.sv
// ---------------------------------------------------------------------------
// rb_commit_unit_pkg
// Shared parameter set and entry layout for the reorder-buffer commit unit.
//   WORD_SIZE  data/address width
//   RB_SIZE    number of RB entries (power of two)
//   RB_INDEX   slot index width, one bit wider than a pointer so that NULL
//              can never name a real slot
//   REG_INDEX  architectural register index width
//   NULL       "no slot" index encoding
// Optional feature macro used by the files importing this package:
//   RB_COMMIT_BYPASS_EN
// ---------------------------------------------------------------------------
package rb_commit_unit_pkg;

    localparam int WORD_SIZE = 32;
    localparam int RB_SIZE   = 8;
    localparam int RB_INDEX  = 4;
    localparam int REG_INDEX = 5;
    localparam int PTR_W     = $clog2(RB_SIZE);

    localparam logic [RB_INDEX-1:0] NULL = {RB_INDEX{1'b1}};

    // One reorder-buffer entry.
    typedef struct packed {
        logic                 busy;
        logic                 stale;
        logic                 done;
        logic                 is_store;
        logic [REG_INDEX-1:0] dest;
        logic [WORD_SIZE-1:0] data;
        logic [WORD_SIZE-1:0] addr;
    } rb_entry_t;

    // Head/tail pointers wrap naturally because RB_SIZE is a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return p + PTR_W'(1);
    endfunction

endpackage

// File: rtl/rb_commit_unit_slot.sv
// ---------------------------------------------------------------------------
// rb_slot
// One reorder-buffer entry: allocate, capture from its CDB slot, clear on
// commit or flush.
// Ports:
//   clk, reset (sync, active-low), flush
//   alloc, alloc_is_store, alloc_dest   : write a new occupant into the slot
//   cdb_valid, cdb_data, cdb_addr       : this slot's word of the CDB arrays
//   clear                               : the entry commits this cycle
//   busy, is_store, dest                : entry fields seen by the commit mux
//   commit_ok, commit_data, commit_addr : result ready for commit + payload
// Macro RB_COMMIT_BYPASS_EN: when defined, a result being captured this cycle
// is already offered for commit (commit_ok / payload taken from the CDB).
// ---------------------------------------------------------------------------
module rb_slot
    import rb_commit_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 alloc,
    input  logic                 alloc_is_store,
    input  logic [REG_INDEX-1:0] alloc_dest,
    input  logic                 cdb_valid,
    input  logic [WORD_SIZE-1:0] cdb_data,
    input  logic [WORD_SIZE-1:0] cdb_addr,
    input  logic                 clear,
    output logic                 busy,
    output logic                 is_store,
    output logic [REG_INDEX-1:0] dest,
    output logic                 commit_ok,
    output logic [WORD_SIZE-1:0] commit_data,
    output logic [WORD_SIZE-1:0] commit_addr
);

    rb_entry_t entry_q, entry_d;
    logic      capture;

    // A stale entry must see the CDB valid from the previous occupant drop
    // before a rising valid can be trusted as its own result.
    assign capture = entry_q.busy && !entry_q.done && !entry_q.stale && cdb_valid;

    always_comb begin
        entry_d = entry_q;
        if (flush) begin
            entry_d.busy  = 1'b0;
            entry_d.stale = 1'b0;
            entry_d.done  = 1'b0;
        end else if (alloc) begin
            entry_d.busy     = 1'b1;
            entry_d.stale    = cdb_valid;
            entry_d.done     = 1'b0;
            entry_d.is_store = alloc_is_store;
            entry_d.dest     = alloc_dest;
        end else begin
            if (entry_q.busy && !entry_q.done && entry_q.stale && !cdb_valid) begin
                entry_d.stale = 1'b0;
            end
            if (capture) begin
                entry_d.done = 1'b1;
                entry_d.data = cdb_data;
                entry_d.addr = cdb_addr;
            end
            if (clear) begin
                entry_d.busy  = 1'b0;
                entry_d.done  = 1'b0;
                entry_d.stale = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign busy     = entry_q.busy;
    assign is_store = entry_q.is_store;
    assign dest     = entry_q.dest;

`ifdef RB_COMMIT_BYPASS_EN
    assign commit_ok   = entry_q.done || capture;
    assign commit_data = entry_q.done ? entry_q.data : cdb_data;
    assign commit_addr = entry_q.done ? entry_q.addr : cdb_addr;
`else
    assign commit_ok   = entry_q.done;
    assign commit_data = entry_q.data;
    assign commit_addr = entry_q.addr;
`endif

endmodule

// File: rtl/rb_commit_unit.sv
// ---------------------------------------------------------------------------
// rb_commit_unit
// Reorder-buffer storage and in-order commit stage behind the CDB data
// controller. Allocates a slot per issued instruction, captures results and
// store addresses from the per-slot CDB arrays, and retires the head entry
// as a register write or a memory store.
// Ports:
//   clk, reset (sync, active-low), flush (squash all entries)
//   issue_valid/issue_is_store/issue_dest -> issue_ready/issue_index
//   CDB_data_data/CDB_data_valid/CDB_data_addr : per-slot results
//   mem_ready                                  : memory accepts a store
//   reg_we/reg_waddr/reg_wdata                 : registered register write
//   mem_we/mem_addr/mem_wdata                  : registered store
//   rb_count                                   : occupied entries
// Macro RB_COMMIT_BYPASS_EN: when defined, a head entry commits on the same
// edge its result is captured.
//
// Issue handshake: an instruction is allocated on a rising edge where
// issue_valid && issue_ready (and no flush). issue_ready depends only on the
// registered count, so a commit on that same edge does not make room for it.
// issue_index is the slot that would be granted (current tail), or NULL while
// no slot can be granted.
// ---------------------------------------------------------------------------
module rb_commit_unit
    import rb_commit_unit_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           issue_valid,
    input  logic                           issue_is_store,
    input  logic [REG_INDEX-1:0]           issue_dest,
    output logic                           issue_ready,
    output logic [RB_INDEX-1:0]            issue_index,
    input  logic [WORD_SIZE*RB_SIZE-1:0]   CDB_data_data,
    input  logic [RB_SIZE-1:0]             CDB_data_valid,
    input  logic [RB_SIZE*WORD_SIZE-1:0]   CDB_data_addr,
    input  logic                           mem_ready,
    output logic                           reg_we,
    output logic [REG_INDEX-1:0]           reg_waddr,
    output logic [WORD_SIZE-1:0]           reg_wdata,
    output logic                           mem_we,
    output logic [WORD_SIZE-1:0]           mem_addr,
    output logic [WORD_SIZE-1:0]           mem_wdata,
    output logic [RB_INDEX-1:0]            rb_count
);

    logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
    logic [RB_INDEX-1:0]  count_q, count_d;
    logic                 reg_we_q, reg_we_d, mem_we_q, mem_we_d;
    logic [REG_INDEX-1:0] reg_waddr_q, reg_waddr_d;
    logic [WORD_SIZE-1:0] reg_wdata_q, reg_wdata_d;
    logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;

    logic [RB_SIZE-1:0]   slot_busy, slot_is_store, slot_ok;
    logic [REG_INDEX-1:0] slot_dest [RB_SIZE];
    logic [WORD_SIZE-1:0] slot_data [RB_SIZE];
    logic [WORD_SIZE-1:0] slot_addr [RB_SIZE];

    logic issue_fire, commit_fire, head_is_store;

    assign issue_ready = (count_q != RB_INDEX'(RB_SIZE));
    assign issue_index = issue_ready ? RB_INDEX'(tail_q) : NULL;

    for (genvar i = 0; i < RB_SIZE; i++) begin : g_slot
        rb_slot u_slot (
            .clk            (clk),
            .reset          (reset),
            .flush          (flush),
            .alloc          (issue_fire && (tail_q == PTR_W'(i))),
            .alloc_is_store (issue_is_store),
            .alloc_dest     (issue_dest),
            .cdb_valid      (CDB_data_valid[i]),
            .cdb_data       (CDB_data_data[i*WORD_SIZE +: WORD_SIZE]),
            .cdb_addr       (CDB_data_addr[i*WORD_SIZE +: WORD_SIZE]),
            .clear          (commit_fire && (head_q == PTR_W'(i))),
            .busy           (slot_busy[i]),
            .is_store       (slot_is_store[i]),
            .dest           (slot_dest[i]),
            .commit_ok      (slot_ok[i]),
            .commit_data    (slot_data[i]),
            .commit_addr    (slot_addr[i])
        );
    end

    always_comb begin
        head_is_store = slot_is_store[head_q];
        issue_fire    = !flush && issue_valid && issue_ready;
        // Stores wait for memory indefinitely; everything else retires as
        // soon as its result is in.
        commit_fire   = !flush && slot_busy[head_q] && slot_ok[head_q] &&
                        (!head_is_store || mem_ready);
    end

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        reg_we_d    = 1'b0;
        mem_we_d    = 1'b0;
        reg_waddr_d = reg_waddr_q;
        reg_wdata_d = reg_wdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (issue_fire) begin
                tail_d = ptr_inc(tail_q);
            end
            if (commit_fire) begin
                head_d = ptr_inc(head_q);
                if (head_is_store) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = slot_addr[head_q];
                    mem_wdata_d = slot_data[head_q];
                end else begin
                    reg_we_d    = 1'b1;
                    reg_waddr_d = slot_dest[head_q];
                    reg_wdata_d = slot_data[head_q];
                end
            end
            case ({issue_fire, commit_fire})
                2'b10:   count_d = count_q + RB_INDEX'(1);
                2'b01:   count_d = count_q - RB_INDEX'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            reg_we_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            reg_we_q    <= reg_we_d;
            mem_we_q    <= mem_we_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign reg_we    = reg_we_q;
    assign reg_waddr = reg_waddr_q;
    assign reg_wdata = reg_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rb_count  = count_q;

endmodule
